// File: rtl/loop_controller_if.sv
// Handshake bundle between the loop controller and its
// driver side: loop request, counter feedback and counter controls.
interface loop_controller_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] reps;
  logic             stall;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             cep;
  logic             cet;
  logic             pe_n;
  logic [WIDTH-1:0] d;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] iter;

  modport master (
    output start, base, limit, reps,
    output stall, abort, q,
    input  cep, cet, pe_n, d,
    input  busy, done, iter
  );

  modport slave (
    input  start, base, limit, reps,
    input  stall, abort, q,
    output cep, cet, pe_n, d,
    output busy, done, iter
  );
endinterface

// File: rtl/loop_controller.sv
// Hardware loop engine: sweeps an external loadable counter
// from base to limit, reps times, then pulses done.
module loop_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  loop_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] base_r;
  logic [WIDTH-1:0] limit_r;
  logic [WIDTH-1:0] reps_r;
  logic [WIDTH-1:0] iter_r;
  logic             done_r;
  logic             busy_r;

  logic [WIDTH-1:0] iter_inc;
  logic             at_end;
  logic             last;
  logic             cep;
  logic             pe_n;

  assign iter_inc = iter_r + 1'b1;
  assign at_end   = (bus.q == limit_r);
  assign last     = (iter_inc == reps_r);

  // Abort wins over everything; load overrides count.
  always_comb begin
    cep  = 1'b0;
    pe_n = 1'b1;
    unique case (state)
      LOAD: begin
        if (!bus.abort) pe_n = 1'b0;
      end
      RUN: begin
        if (!bus.abort && !bus.stall) begin
          if (!at_end)   cep  = 1'b1;
          else if (!last) pe_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.cep  = cep;
  assign bus.cet  = cep;
  assign bus.pe_n = pe_n;
  assign bus.d    = base_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.iter = iter_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      base_r  <= '0;
      limit_r <= '0;
      reps_r  <= '0;
      iter_r  <= '0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            iter_r <= '0;
            if (bus.reps != '0) begin
              base_r  <= bus.base;
              limit_r <= bus.limit;
              reps_r  <= bus.reps;
              state   <= LOAD;
              busy_r  <= 1'b1;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else if (!bus.stall && at_end) begin
            iter_r <= iter_inc;
            if (last) begin
              done_r <= 1'b1;
              state  <= IDLE;
              busy_r <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loop_controller.sv
// Bench for loop_controller: counter model, directed table,
// hand-written corner sequences and a randomized sweep model.
module tb_loop_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cnt = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  loop_controller_if #(.WIDTH(8)) bus ();

  loop_controller #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // External loadable up-counter: load beats count.
  always @(posedge clk) begin
    if (!bus.pe_n)                cnt <= bus.d;
    else if (bus.cep && bus.cet) cnt <= cnt + 8'd1;
  end
  assign bus.q = cnt;

  typedef struct {
    logic [7:0]  base;
    logic [7:0]  limit;
    logic [7:0]  reps;
    logic [15:0] stall_mask;
    int          exp_done;
    int          exp_iter;
    int          exp_pe_lows;
    int          exp_busy;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic run_case(input vec_t v, input int idx);
    int         done_at;
    int         pe_lows;
    int         busy_cnt;
    logic [7:0] q0;
    done_at  = -1;
    pe_lows  = 0;
    busy_cnt = 0;
    q0       = cnt;
    for (int c = 0; c < 64 && done_at < 0; c++) begin
      @(negedge clk);
      bus.start = (c == 0);
      bus.abort = 1'b0;
      bus.base  = v.base;
      bus.limit = v.limit;
      bus.reps  = v.reps;
      bus.stall = (c < 16) ? v.stall_mask[c] : 1'b0;
      #1;
      if (c > 0 && bus.done) done_at = c;
      if (!bus.pe_n) pe_lows++;
      if (bus.busy) busy_cnt++;
    end
    chk($sformatf("vec%0d done_cycle", idx), done_at, v.exp_done);
    chk($sformatf("vec%0d iter", idx), bus.iter, v.exp_iter);
    chk($sformatf("vec%0d busy_at_done", idx), bus.busy, 0);
    chk($sformatf("vec%0d pe_lows", idx), pe_lows, v.exp_pe_lows);
    chk($sformatf("vec%0d busy_cycles", idx), busy_cnt, v.exp_busy);
    chk($sformatf("vec%0d q_final", idx), cnt,
        (v.reps == 0) ? q0 : v.limit);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic random_loops(input int trials);
    logic [7:0] qv [$];
    int         kind [$];
    logic [7:0] b, l, r;
    int         span;
    int         sweeps;
    int         guard;
    for (int t = 0; t < trials; t++) begin
      b    = 8'($urandom);
      span = (t % 8 == 7) ? int'($urandom_range(20, 60))
                          : int'($urandom_range(0, 6));
      l    = b + 8'(span);
      r    = 8'($urandom_range(1, 4));
      qv.delete();
      kind.delete();
      for (int i = 0; i < int'(r); i++)
        for (int k = 0; k <= span; k++) begin
          qv.push_back(b + 8'(k));
          kind.push_back(k != span ? 0 : (i == int'(r) - 1 ? 2 : 1));
        end
      @(negedge clk);
      bus.start = 1'b1;
      bus.base  = b;
      bus.limit = l;
      bus.reps  = r;
      bus.stall = ($urandom_range(0, 3) == 0);
      #1 chk("rnd idle_busy", bus.busy, 0);
      @(negedge clk);
      bus.start = 1'b0;
      bus.stall = ($urandom_range(0, 1) == 0);
      #1;
      chk("rnd load_pe", bus.pe_n, 0);
      chk("rnd load_cep", bus.cep, 0);
      chk("rnd load_busy", bus.busy, 1);
      sweeps = 0;
      guard  = 0;
      while (qv.size() > 0 && guard < 4000) begin
        guard++;
        @(negedge clk);
        bus.stall = ($urandom_range(0, 3) == 0);
        #1;
        chk("rnd busy", bus.busy, 1);
        chk("rnd cet", bus.cet, bus.cep);
        chk("rnd q", cnt, qv[0]);
        chk("rnd iter", bus.iter, sweeps);
        if (bus.stall) begin
          chk("rnd stall_cep", bus.cep, 0);
          chk("rnd stall_pe", bus.pe_n, 1);
        end else begin
          chk("rnd cep", bus.cep, kind[0] == 0);
          chk("rnd pe", bus.pe_n, kind[0] != 1);
          if (kind[0] != 0) sweeps++;
          void'(qv.pop_front());
          void'(kind.pop_front());
        end
      end
      chk("rnd guard", qv.size(), 0);
      @(negedge clk);
      bus.stall = 1'b0;
      #1;
      chk("rnd done", bus.done, 1);
      chk("rnd done_busy", bus.busy, 0);
      chk("rnd done_iter", bus.iter, r);
      chk("rnd done_q", cnt, l);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    logic [7:0] qsave;
    logic       seen;

    vecs[0] = '{8'h03, 8'h05, 8'd2, 16'h0000, 8, 2, 2, 7};
    vecs[1] = '{8'hFE, 8'h01, 8'd1, 16'h0000, 6, 1, 1, 5};
    vecs[2] = '{8'h07, 8'h07, 8'd3, 16'h0000, 5, 3, 3, 4};
    vecs[3] = '{8'h03, 8'h05, 8'd2, 16'h0058, 11, 2, 2, 10};
    vecs[4] = '{8'h40, 8'h50, 8'd0, 16'h0000, 1, 0, 0, 0};

    rst       = 1'b1;
    bus.base  = 8'h00;
    bus.limit = 8'h00;
    bus.reps  = 8'h00;
    idle_inputs();
    #1;
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset iter", bus.iter, 0);
    chk("reset cep", bus.cep, 0);
    chk("reset cet", bus.cet, 0);
    chk("reset pe", bus.pe_n, 1);
    chk("reset d", bus.d, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_case(vecs[i], i);

    // Reset in the middle of a running loop.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.start = (c == 0);
      bus.base  = 8'h10;
      bus.limit = 8'h20;
      bus.reps  = 8'd4;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr busy", bus.busy, 0);
    chk("mr done", bus.done, 0);
    chk("mr iter", bus.iter, 0);
    chk("mr cep", bus.cep, 0);
    chk("mr pe", bus.pe_n, 1);
    qsave = cnt;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mr q_kept", cnt, qsave);
    run_case(vecs[0], 10);

    // Abort at end of first sweep, with a fresh start alongside.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.start = (c == 0);
      bus.base  = 8'h03;
      bus.limit = 8'h05;
      bus.reps  = 8'd2;
    end
    @(negedge clk);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.stall = 1'b0;
    #1;
    chk("abort cep", bus.cep, 0);
    chk("abort pe", bus.pe_n, 1);
    chk("abort busy_same", bus.busy, 1);
    chk("abort q", cnt, 8'h05);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("abort idle", bus.busy, 0);
    chk("abort iter", bus.iter, 0);
    chk("abort q_held", cnt, 8'h05);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 seen = seen | bus.done | bus.busy;
    end
    chk("abort no_done", seen, 0);

    // Abort in idle beats a simultaneous start.
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.reps  = 8'd2;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("idle_abort busy", bus.busy, 0);
    chk("idle_abort done", bus.done, 0);

    random_loops(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
